bits_sched: RTL and testbench
=============================

Name: bits_sched

Overview:
- Controller and round-robin arbiter in front of the `bits` unpacker.
- Accepts 32-bit source words and forwards them to `bits` only when the 1024-bit buffer has room.
- Shares the variable-length bit-read port among NREQ requesters; never issues a read for more bits than are buffered.
- Routes each 2-cycle-latency `bits` response back to the requester that was granted.

Parameters:
NREQ, 4, number of requesters (2..8)
CAP_BITS, 1024, bit capacity of the `bits` buffer
TAG_DEPTH, 4, depth of the outstanding-grant tag FIFO (must be >= 3)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-low
src_valid  in  1  upstream word available
src_word  in  32  upstream word
src_ready  out  1  word accepted this cycle when src_valid=1
pushin  out  1  to `bits`: write word (= src_valid & src_ready)
datain  out  32  to `bits`: src_word passthrough
req_valid  in  NREQ  per-requester read request
req_len  in  4*NREQ  per-requester length, slice k = [4k+3:4k], 0..15
req_ready  out  NREQ  one-hot grant, combinational
reqin  out  1  to `bits`: read strobe (= |req_ready)
reqlen  out  4  to `bits`: length of granted request
pushout  in  1  from `bits`: response valid
lenout  in  4  from `bits`: response length
dataout  in  15  from `bits`: response data, LSB = first bit
rsp_valid  out  NREQ  one-hot response strobe, registered
rsp_len  out  4  response length, registered
rsp_data  out  15  response data, registered, masked to rsp_len bits
occupancy  out  11  unread bits in buffer, registered
err_unexp  out  1  sticky: pushout arrived with tag FIFO empty

Behaviour:
- Reset (rst=0 at an edge):
  - occupancy=0, rr_ptr=0, tag FIFO empty.
  - rsp_valid=0, rsp_len=0, rsp_data=0, err_unexp=0.
  - `bits` shares this reset, so no stale pushout follows.
  - Reset mid-operation discards all in-flight grants.
- Source acceptance:
  - src_ready = (occupancy + 32 <= CAP_BITS), computed from the registered occupancy only.
  - Same-cycle grants do not free space; this is conservative and deliberate.
  - src_ready is held 0 while rst=0.
- Arbitration, head-of-line round robin:
  - The head is the first k with req_valid[k]=1, searching from rr_ptr upward modulo NREQ.
  - Grant the head iff req_len[head] <= occupancy (registered value).
  - If the head lacks bits: no grant that cycle, and lower-priority requesters are NOT granted (prevents starvation of long reads).
  - At most one grant per cycle. On a grant, rr_ptr <= head+1 mod NREQ; otherwise rr_ptr is unchanged.
  - No grant while rst=0.
- Zero-length requests:
  - req_len=0 is always eligible.
  - It consumes 0 bits and still produces a response with rsp_len=0, rsp_data=0.
- Occupancy update, each edge:
  - occupancy <= occupancy + (pushin ? 32 : 0) - (grant ? reqlen : 0).
  - Width 11 bits; the range 0..1024 is guaranteed by the rules above.
  - A word pushed at edge N is usable from the cycle after N.
- Tag FIFO:
  - On a grant, push the head index.
  - On pushout=1, pop the head tag t; on the next edge set rsp_valid[t]=1, rsp_len=lenout, rsp_data=dataout & ((1<<lenout)-1).
  - rsp_valid is 0 in every other cycle. rsp_len and rsp_data hold their values when not valid.
  - Simultaneous push and pop are both performed.
  - A push to a full FIFO cannot occur: the `bits` latency is 2 and there is 1 grant per cycle.
- Latency and ordering:
  - Grant in cycle C → `bits` pushout in C+2 → rsp_valid in C+3.
  - Responses return in grant order.
- Error handling:
  - pushout=1 with the tag FIFO empty: no rsp_valid is raised.
  - err_unexp <= 1 and stays 1 until reset.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with src_valid=1 and req_valid=all ones → src_ready=0, req_ready=0, occupancy=0, rsp_valid=0, err_unexp=0.
2. Single read: push word 0xA5A50F0F; next cycle req_valid[0]=1, len=4 → req_ready[0]=1 that cycle, occupancy 32→28, rsp_valid[0]=1 three cycles later, rsp_len=4, rsp_data=0x000F.
3. Head-of-line stall: occupancy=10, rr_ptr=1, req1 len=12, req2 len=3 → no grant; push one word → next cycle grant req1 (occupancy 42→30), following cycle grant req2 (→27); responses arrive in order 1 then 2.
4. Round robin: occupancy=64, all four requesters valid, len=1, held → grants 0,1,2,3,0 on consecutive cycles; rsp_valid order 0,1,2,3,0; occupancy decreases by 1 per cycle.
5. Full: push 32 words with no requests → occupancy=1024, src_ready=0; grant len=15 → 1009, src_ready stays 0; two more len=15 grants → 979, src_ready=1, next word accepted → 1011.
6. Unexpected response: force pushout=1 with no grant outstanding → no rsp_valid, err_unexp=1, still 1 after 10 idle cycles, 0 after reset.

Source files
------------

// File: rtl/bits_sched.sv
// bits_sched: source-word gate, head-of-line round-robin read arbiter and response router
// sitting in front of the `bits` unpacker.
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-low reset
//   src_valid/src_word     upstream 32-bit words; src_ready says the word is taken
//   pushin/datain          word write into `bits`
//   req_valid/req_len      per-requester read requests, 4-bit length slice per requester
//   req_ready              one-hot combinational grant
//   reqin/reqlen           read strobe and length into `bits`
//   pushout/lenout/dataout `bits` response, two cycles after reqin
//   rsp_valid/len/data     registered response routed to the granted requester
//   occupancy              unread bits held in `bits`
//   err_unexp              sticky flag: response arrived with no grant outstanding
module bits_sched #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned CAP_BITS  = 1024,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_valid,
  input  logic [31:0]       src_word,
  output logic              src_ready,
  output logic              pushin,
  output logic [31:0]       datain,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_len,
  output logic [NREQ-1:0]   req_ready,
  output logic              reqin,
  output logic [3:0]        reqlen,
  input  logic              pushout,
  input  logic [3:0]        lenout,
  input  logic [14:0]       dataout,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [3:0]        rsp_len,
  output logic [14:0]       rsp_data,
  output logic [10:0]       occupancy,
  output logic              err_unexp
);

  localparam int unsigned IdxW = $clog2(NREQ);
  localparam int unsigned PtrW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(TAG_DEPTH + 1);

  logic [10:0]      occ_q, occ_d;
  logic [11:0]      occ_plus_word;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]  head_idx;
  logic             head_found;
  logic [3:0]       head_len;
  logic             grant;
  int unsigned      cand;

  logic [IdxW-1:0]  tag_mem [TAG_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  tag_cnt_q, tag_cnt_d;
  logic             tag_empty;
  logic             tag_push, tag_pop;
  logic [IdxW-1:0]  rsp_tag;
  logic [14:0]      len_mask;

  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [3:0]       rsp_len_q;
  logic [14:0]      rsp_data_q;
  logic             err_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Space check uses only the registered occupancy; same-cycle reads are not credited.
  assign occ_plus_word = {1'b0, occ_q} + 12'd32;
  assign src_ready     = rst & (occ_plus_word <= 12'(CAP_BITS));
  assign pushin        = src_valid & src_ready;
  assign datain        = src_word;

  // Head = first valid requester at or after rr_ptr (wrapping).
  always_comb begin
    head_found = 1'b0;
    head_idx   = '0;
    head_len   = '0;
    cand       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(rr_ptr_q) + i) % NREQ;
      if (!head_found && req_valid[cand]) begin
        head_found = 1'b1;
        head_idx   = IdxW'(cand);
        head_len   = req_len[4*cand +: 4];
      end
    end
  end

  // Only the head may be granted; a short request behind it waits so long reads cannot starve.
  assign grant     = rst & head_found & ({7'd0, head_len} <= occ_q);
  assign req_ready = grant ? ({{(NREQ-1){1'b0}}, 1'b1} << head_idx) : '0;
  assign reqin     = grant;
  assign reqlen    = grant ? head_len : 4'd0;

  always_comb begin
    occ_d = occ_q + (pushin ? 11'd32 : 11'd0) - (grant ? {7'd0, head_len} : 11'd0);
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (head_idx == IdxW'(NREQ - 1)) ? '0 : head_idx + 1'b1;
    end
  end

  // Tag FIFO: remembers which requester owns each in-flight `bits` read.
  assign tag_empty = (tag_cnt_q == '0);
  assign tag_push  = grant;
  assign tag_pop   = pushout & ~tag_empty;
  assign rsp_tag   = tag_mem[rd_ptr_q];

  always_comb begin
    tag_cnt_d = tag_cnt_q;
    if (tag_push && !tag_pop) begin
      tag_cnt_d = tag_cnt_q + 1'b1;
    end else if (!tag_push && tag_pop) begin
      tag_cnt_d = tag_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_mem[wr_ptr_q] <= head_idx;
    end
  end

  // lenout=0 shifts everything out, giving an all-zero mask.
  assign len_mask    = 15'h7FFF >> (4'd15 - lenout);
  assign rsp_valid_d = tag_pop ? ({{(NREQ-1){1'b0}}, 1'b1} << rsp_tag) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_q       <= '0;
      rr_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tag_cnt_q   <= '0;
      rsp_valid_q <= '0;
      rsp_len_q   <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      rr_ptr_q    <= rr_ptr_d;
      tag_cnt_q   <= tag_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      if (tag_push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (tag_pop) begin
        rd_ptr_q   <= ptr_inc(rd_ptr_q);
        rsp_len_q  <= lenout;
        rsp_data_q <= dataout & len_mask;
      end
      if (pushout && tag_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign occupancy = occ_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_len   = rsp_len_q;
  assign rsp_data  = rsp_data_q;
  assign err_unexp = err_q;

endmodule

// File: tb/tb_bits_sched.sv
module tb_bits_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        src_valid = 1'b0;
  logic [31:0] src_word = '0;
  logic        src_ready;
  logic        pushin;
  logic [31:0] datain;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_len = '0;
  logic [3:0]  req_ready;
  logic        reqin;
  logic [3:0]  reqlen;
  logic        pushout;
  logic [3:0]  lenout;
  logic [14:0] dataout;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_len;
  logic [14:0] rsp_data;
  logic [10:0] occupancy;
  logic        err_unexp;
  logic        inject_po = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bits_sched #(.NREQ(4), .CAP_BITS(1024), .TAG_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_word(src_word), .src_ready(src_ready),
    .pushin(pushin), .datain(datain),
    .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
    .reqin(reqin), .reqlen(reqlen),
    .pushout(pushout), .lenout(lenout), .dataout(dataout),
    .rsp_valid(rsp_valid), .rsp_len(rsp_len), .rsp_data(rsp_data),
    .occupancy(occupancy), .err_unexp(err_unexp)
  );

  // Behavioural `bits`: LSB-first bit FIFO, reads answered two cycles later.
  // Bits above the response length are driven to 1 so masking is exercised.
  logic [2047:0] mbuf_q, mbuf_d;
  logic [11:0]   mcnt_q, mcnt_d, mcnt_left;
  logic [3:0]    mlen;
  logic [14:0]   mmask, mdata;
  logic          p1_v, p2_v;
  logic [3:0]    p1_len, p2_len;
  logic [14:0]   p1_data, p2_data;

  always_comb begin
    mlen      = reqin ? reqlen : 4'd0;
    mcnt_left = mcnt_q - {8'd0, mlen};
    mbuf_d    = mbuf_q >> mlen;
    if (pushin) mbuf_d = mbuf_d | ({2016'd0, datain} << mcnt_left);
    mcnt_d    = mcnt_left + (pushin ? 12'd32 : 12'd0);
    mmask     = 15'h7FFF >> (4'd15 - mlen);
    mdata     = (mbuf_q[14:0] & mmask) | ~mmask;
  end

  always @(posedge clk) begin
    if (!rst) begin
      mbuf_q <= '0; mcnt_q <= '0;
      p1_v <= 1'b0; p1_len <= '0; p1_data <= '0;
      p2_v <= 1'b0; p2_len <= '0; p2_data <= '0;
    end else begin
      mbuf_q <= mbuf_d; mcnt_q <= mcnt_d;
      p1_v <= reqin; p1_len <= mlen; p1_data <= mdata;
      p2_v <= p1_v; p2_len <= p1_len; p2_data <= p1_data;
    end
  end

  assign pushout = p2_v | inject_po;
  assign lenout  = p2_len;
  assign dataout = p2_data;

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset();
    nxt();
    rst = 1'b0; src_valid = 1'b0; req_valid = '0; req_len = '0; inject_po = 1'b0;
    nxt();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    nxt();
    rst = 1'b0; src_valid = 1'b1; src_word = 32'hDEADBEEF; req_valid = 4'hF; req_len = '0;
    repeat (3) begin
      nxt();
      #1;
      checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL reset_src_ready got %0h want 0", src_ready); end
      checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready got %0h want 0", req_ready); end
      checks++; if (occupancy !== 11'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
      checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL reset_rsp_valid got %0h want 0", rsp_valid); end
      checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL reset_err got %0h want 0", err_unexp); end
    end
    src_valid = 1'b0; req_valid = '0;
  endtask

  task automatic test_single_read();
    nxt();
    rst = 1'b1; src_valid = 1'b1; src_word = 32'hA5A50F0F;
    #1;
    checks++; if (pushin !== 1'b1) begin errors++; $display("FAIL single_pushin got %0h want 1", pushin); end
    checks++; if (datain !== 32'hA5A50F0F) begin errors++; $display("FAIL single_datain got %0h want a5a50f0f", datain); end
    nxt();
    src_valid = 1'b0; req_valid = 4'b0001; req_len[3:0] = 4'd4;
    #1;
    checks++; if (occupancy !== 11'd32) begin errors++; $display("FAIL single_occ32 got %0d want 32", occupancy); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got %0h want 1", req_ready); end
    checks++; if (reqlen !== 4'd4) begin errors++; $display("FAIL single_reqlen got %0d want 4", reqlen); end
    nxt();
    req_valid = '0;
    #1;
    checks++; if (occupancy !== 11'd28) begin errors++; $display("FAIL single_occ28 got %0d want 28", occupancy); end
    checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL single_rsp_early1 got %0h want 0", rsp_valid); end
    nxt(); #1;
    checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL single_rsp_early2 got %0h want 0", rsp_valid); end
    nxt(); #1;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid got %0h want 1", rsp_valid); end
    checks++; if (rsp_len !== 4'd4) begin errors++; $display("FAIL single_rsp_len got %0d want 4", rsp_len); end
    checks++; if (rsp_data !== 15'h000F) begin errors++; $display("FAIL single_rsp_data got %0h want f", rsp_data); end
    nxt(); #1;
    checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL single_rsp_drop got %0h want 0", rsp_valid); end
    checks++; if (rsp_len !== 4'd4) begin errors++; $display("FAIL single_rsp_hold got %0d want 4", rsp_len); end
  endtask

  task automatic test_hol_stall();
    do_reset();
    nxt();
    src_valid = 1'b1; src_word = 32'hFFC00000;
    nxt();
    src_valid = 1'b0; req_valid = 4'b1000; req_len[15:12] = 4'd15;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL hol_grant3 got %0h want 8", req_ready); end
    nxt();
    req_valid = 4'b0001; req_len[3:0] = 4'd7;
    #1;
    checks++; if (occupancy !== 11'd17) begin errors++; $display("FAIL hol_occ17 got %0d want 17", occupancy); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL hol_grant0 got %0h want 1", req_ready); end
    nxt();
    req_valid = 4'b0110; req_len[7:4] = 4'd12; req_len[11:8] = 4'd3;
    #1;
    checks++; if (occupancy !== 11'd10) begin errors++; $display("FAIL hol_occ10 got %0d want 10", occupancy); end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL hol_stall1 got %0h want 0", req_ready); end
    nxt();
    src_valid = 1'b1; src_word = 32'h0000001E;
    #1;
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL hol_stall2 got %0h want 0", req_ready); end
    checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL hol_rsp3 got %0h want 8", rsp_valid); end
    checks++; if (rsp_len !== 4'd15 || rsp_data !== 15'h0) begin errors++; $display("FAIL hol_rsp3_data got %0d/%0h want 15/0", rsp_len, rsp_data); end
    nxt();
    src_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 11'd42) begin errors++; $display("FAIL hol_occ42 got %0d want 42", occupancy); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hol_grant1 got %0h want 2", req_ready); end
    checks++; if (rsp_valid !== 4'b0001 || rsp_len !== 4'd7) begin errors++; $display("FAIL hol_rsp0 got %0h/%0d want 1/7", rsp_valid, rsp_len); end
    nxt();
    req_valid = 4'b0100;
    #1;
    checks++; if (occupancy !== 11'd30) begin errors++; $display("FAIL hol_occ30 got %0d want 30", occupancy); end
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL hol_grant2 got %0h want 4", req_ready); end
    nxt();
    req_valid = '0;
    #1;
    checks++; if (occupancy !== 11'd27) begin errors++; $display("FAIL hol_occ27 got %0d want 27", occupancy); end
    nxt(); #1;
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL hol_rsp1 got %0h want 2", rsp_valid); end
    checks++; if (rsp_len !== 4'd12 || rsp_data !== 15'h0BFF) begin errors++; $display("FAIL hol_rsp1_data got %0d/%0h want 12/bff", rsp_len, rsp_data); end
    nxt(); #1;
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL hol_rsp2 got %0h want 4", rsp_valid); end
    checks++; if (rsp_len !== 4'd3 || rsp_data !== 15'h0007) begin errors++; $display("FAIL hol_rsp2_data got %0d/%0h want 3/7", rsp_len, rsp_data); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_gnt [5];
    logic [14:0] exp_bit [5];
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
    // Word 0x00000005 read one bit at a time: 1,0,1,0,0.
    exp_bit[0] = 15'd1; exp_bit[1] = 15'd0; exp_bit[2] = 15'd1;
    exp_bit[3] = 15'd0; exp_bit[4] = 15'd0;
    do_reset();
    nxt();
    src_valid = 1'b1; src_word = 32'h00000005;
    nxt();
    src_word = 32'h0;
    nxt();
    src_valid = 1'b0; req_len = 16'h1111;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) req_valid = 4'hF;
      if (i == 5) req_valid = 4'h0;
      #1;
      if (i < 5) begin
        checks++; if (req_ready !== exp_gnt[i]) begin errors++; $display("FAIL rr_grant%0d got %0h want %0h", i, req_ready, exp_gnt[i]); end
        checks++; if (occupancy !== 11'(64 - i)) begin errors++; $display("FAIL rr_occ%0d got %0d want %0d", i, occupancy, 64 - i); end
      end else begin
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rr_idle%0d got %0h want 0", i, req_ready); end
      end
      if (i >= 3 && i < 8) begin
        checks++; if (rsp_valid !== exp_gnt[i-3]) begin errors++; $display("FAIL rr_rsp%0d got %0h want %0h", i, rsp_valid, exp_gnt[i-3]); end
        checks++; if (rsp_len !== 4'd1 || rsp_data !== exp_bit[i-3]) begin errors++; $display("FAIL rr_rsp_data%0d got %0d/%0h want 1/%0h", i, rsp_len, rsp_data, exp_bit[i-3]); end
      end else begin
        checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL rr_norsp%0d got %0h want 0", i, rsp_valid); end
      end
      nxt();
    end
  endtask

  task automatic test_full();
    do_reset();
    nxt();
    src_valid = 1'b1; src_word = 32'h0;
    for (int i = 0; i < 32; i++) begin
      #1;
      checks++; if (src_ready !== 1'b1 || occupancy !== 11'(32 * i)) begin errors++; $display("FAIL full_fill%0d got %0h/%0d want 1/%0d", i, src_ready, occupancy, 32 * i); end
      nxt();
    end
    req_valid = 4'b0001; req_len[3:0] = 4'd15;
    #1;
    checks++; if (occupancy !== 11'd1024) begin errors++; $display("FAIL full_occ1024 got %0d want 1024", occupancy); end
    checks++; if (src_ready !== 1'b0 || pushin !== 1'b0) begin errors++; $display("FAIL full_ready1024 got %0h/%0h want 0/0", src_ready, pushin); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL full_grant_a got %0h want 1", req_ready); end
    nxt(); #1;
    checks++; if (occupancy !== 11'd1009 || src_ready !== 1'b0) begin errors++; $display("FAIL full_occ1009 got %0d/%0h want 1009/0", occupancy, src_ready); end
    nxt(); #1;
    checks++; if (occupancy !== 11'd994 || src_ready !== 1'b0) begin errors++; $display("FAIL full_occ994 got %0d/%0h want 994/0", occupancy, src_ready); end
    nxt();
    req_valid = '0;
    #1;
    checks++; if (occupancy !== 11'd979 || src_ready !== 1'b1) begin errors++; $display("FAIL full_occ979 got %0d/%0h want 979/1", occupancy, src_ready); end
    nxt();
    src_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 11'd1011 || src_ready !== 1'b0) begin errors++; $display("FAIL full_occ1011 got %0d/%0h want 1011/0", occupancy, src_ready); end
  endtask

  task automatic test_unexpected();
    do_reset();
    nxt(); nxt();
    inject_po = 1'b1;
    #1;
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL unexp_pre got %0h want 0", err_unexp); end
    nxt();
    inject_po = 1'b0;
    #1;
    checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL unexp_set got %0h want 1", err_unexp); end
    checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL unexp_rsp got %0h want 0", rsp_valid); end
    repeat (10) begin
      nxt(); #1;
      checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL unexp_idle_rsp got %0h want 0", rsp_valid); end
    end
    checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL unexp_sticky got %0h want 1", err_unexp); end
    nxt();
    rst = 1'b0;
    nxt(); #1;
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL unexp_clear got %0h want 0", err_unexp); end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_hol_stall();
    test_round_robin();
    test_full();
    test_unexpected();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
